// File: rtl/nv_nvdla_mcif_write_eg_gen_if.sv
// AXI write-response (B) channel bundle between the NoC and the MCIF egress.
interface nv_nvdla_mcif_write_eg_gen_if #(
    parameter int unsigned AXID_W = 8
);
    logic              noc2mcif_axi_b_bvalid;
    logic              noc2mcif_axi_b_bready;
    logic [AXID_W-1:0] noc2mcif_axi_b_bid;
    logic [1:0]        noc2mcif_axi_b_bresp;

    modport master (
        output noc2mcif_axi_b_bvalid,
        output noc2mcif_axi_b_bid,
        output noc2mcif_axi_b_bresp,
        input  noc2mcif_axi_b_bready
    );

    modport slave (
        input  noc2mcif_axi_b_bvalid,
        input  noc2mcif_axi_b_bid,
        input  noc2mcif_axi_b_bresp,
        output noc2mcif_axi_b_bready
    );
endinterface

// File: rtl/nv_nvdla_mcif_write_eg_gen.sv
// MCIF write-response egress: 2-entry B-channel skid buffer, per-client context
// match, registered completion / credit-return pulses and sticky error flags.
module nv_nvdla_mcif_write_eg_gen #(
    parameter int unsigned NUM_CLIENTS = 5,
    parameter int unsigned AXID_W      = 8,
    parameter int unsigned LEN_W       = 2
) (
    input  logic                             nvdla_core_clk,
    input  logic                             nvdla_core_rstn,
    nv_nvdla_mcif_write_eg_gen_if.slave      b_if,
    input  logic [NUM_CLIENTS-1:0]           cq_rd_pvld,
    output logic [NUM_CLIENTS-1:0]           cq_rd_prdy,
    input  logic [NUM_CLIENTS*(LEN_W+1)-1:0] cq_rd_pd,
    output logic [NUM_CLIENTS-1:0]           mcif2client_wr_rsp_complete,
    output logic                             eg2ig_axi_vld,
    output logic [LEN_W-1:0]                 eg2ig_axi_len,
    output logic [NUM_CLIENTS-1:0]           wr_rsp_err,
    input  logic [NUM_CLIENTS-1:0]           wr_rsp_err_clr,
    output logic                             wr_rsp_badid
);

    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_ONE   = 2'd1,
        SK_FULL  = 2'd2
    } skid_e;

    // Buffer entry: {client id[2:0], bresp[1:0]}; entry 0 is always the head.
    skid_e              state_q, state_d;
    logic [4:0]         ent0_q, ent0_d;
    logic [4:0]         ent1_q, ent1_d;
    logic               bready_q, bready_d;

    logic [NUM_CLIENTS-1:0] cmp_q, cmp_d;
    logic                   vld_q, vld_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [NUM_CLIENTS-1:0] err_q, err_d;
    logic                   bad_q, bad_d;

    logic                   head_vld;
    logic [2:0]             hid;
    logic [1:0]             hresp;
    logic [NUM_CLIENTS-1:0] sel;
    logic [LEN_W:0]         hentry;
    logic                   in_range;
    logic                   push;
    logic                   pop;
    logic [4:0]             in_ent;
    logic                   bid_unused;

    assign bid_unused = ^b_if.noc2mcif_axi_b_bid;
    assign in_ent     = {b_if.noc2mcif_axi_b_bid[2:0], b_if.noc2mcif_axi_b_bresp};

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q  <= SK_EMPTY;
            ent0_q   <= '0;
            ent1_q   <= '0;
            bready_q <= 1'b0;
            cmp_q    <= '0;
            vld_q    <= 1'b0;
            len_q    <= '0;
            err_q    <= '0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            bready_q <= bready_d;
            cmp_q    <= cmp_d;
            vld_q    <= vld_d;
            len_q    <= len_d;
            err_q    <= err_d;
            bad_q    <= bad_d;
        end
    end

    always_comb begin
        head_vld   = (state_q != SK_EMPTY);
        hid        = ent0_q[4:2];
        hresp      = ent0_q[1:0];
        sel        = '0;
        hentry     = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            if (hid == 3'(i)) begin
                sel[i] = 1'b1;
                hentry = cq_rd_pd[i*(LEN_W+1) +: (LEN_W+1)];
            end
        end
        in_range   = |sel;
        cq_rd_prdy = head_vld ? (sel & cq_rd_pvld) : '0;
        // Out-of-range heads drain unconditionally so they cannot block the buffer.
        pop        = head_vld & (~in_range | (|(sel & cq_rd_pvld)));
        push       = b_if.noc2mcif_axi_b_bvalid & bready_q;

        state_d = state_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        unique case (state_q)
            SK_EMPTY: begin
                if (push) begin
                    ent0_d  = in_ent;
                    state_d = SK_ONE;
                end
            end
            SK_ONE: begin
                if (push && pop) begin
                    ent0_d = in_ent;
                end else if (push) begin
                    ent1_d  = in_ent;
                    state_d = SK_FULL;
                end else if (pop) begin
                    state_d = SK_EMPTY;
                end
            end
            SK_FULL: begin
                if (pop) begin
                    ent0_d  = ent1_q;
                    state_d = SK_ONE;
                end
            end
            default: state_d = SK_EMPTY;
        endcase
        bready_d = (state_d != SK_FULL);

        vld_d = pop & in_range;
        cmp_d = (vld_d && hentry[0]) ? sel : '0;
        len_d = vld_d ? hentry[LEN_W:1] : '0;
        // Set takes priority over a same-cycle clear.
        err_d = (err_q & ~wr_rsp_err_clr) | ((vld_d && (hresp != 2'b00)) ? sel : '0);
        bad_d = bad_q | (pop & ~in_range);
    end

    assign b_if.noc2mcif_axi_b_bready = bready_q;
    assign mcif2client_wr_rsp_complete = cmp_q;
    assign eg2ig_axi_vld               = vld_q;
    assign eg2ig_axi_len               = len_q;
    assign wr_rsp_err                  = err_q;
    assign wr_rsp_badid                = bad_q;

endmodule

// File: tb/tb_nv_nvdla_mcif_write_eg_gen.sv
// Directed self-checking bench for the MCIF write-response egress (5 clients).
module tb_nv_nvdla_mcif_write_eg_gen;

    localparam int unsigned NC    = 5;
    localparam int unsigned LW    = 2;
    localparam int unsigned IDW   = 8;

    logic          clk;
    logic          rstn;
    logic [NC-1:0] pvld;
    logic [NC-1:0] prdy;
    logic [NC*(LW+1)-1:0] pd;
    logic [NC-1:0] cmp;
    logic          vld;
    logic [LW-1:0] len;
    logic [NC-1:0] err;
    logic [NC-1:0] clr;
    logic          bad;

    int unsigned n_cmp;
    int unsigned n_err;

    nv_nvdla_mcif_write_eg_gen_if #(.AXID_W(IDW)) b_if ();

    nv_nvdla_mcif_write_eg_gen #(
        .NUM_CLIENTS(NC),
        .AXID_W     (IDW),
        .LEN_W      (LW)
    ) dut (
        .nvdla_core_clk             (clk),
        .nvdla_core_rstn            (rstn),
        .b_if                       (b_if.slave),
        .cq_rd_pvld                 (pvld),
        .cq_rd_prdy                 (prdy),
        .cq_rd_pd                   (pd),
        .mcif2client_wr_rsp_complete(cmp),
        .eg2ig_axi_vld              (vld),
        .eg2ig_axi_len              (len),
        .wr_rsp_err                 (err),
        .wr_rsp_err_clr             (clr),
        .wr_rsp_badid               (bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs just after the edge, then check outputs of that cycle.
    task automatic do_slot(input string tag, input logic bv, input logic [7:0] bid,
                           input logic [1:0] bresp, input logic [NC-1:0] pv,
                           input logic [NC-1:0] cl, input logic e_rdy,
                           input logic [NC-1:0] e_prdy, input logic [NC-1:0] e_cmp,
                           input logic e_vld, input logic [LW-1:0] e_len,
                           input logic [NC-1:0] e_err, input logic e_bad);
        @(posedge clk);
        #1;
        b_if.noc2mcif_axi_b_bvalid = bv;
        b_if.noc2mcif_axi_b_bid    = bid;
        b_if.noc2mcif_axi_b_bresp  = bresp;
        pvld = pv;
        clr  = cl;
        #1;
        check_eq({tag, ".bready"}, 32'(b_if.noc2mcif_axi_b_bready), 32'(e_rdy));
        check_eq({tag, ".prdy"},   32'(prdy), 32'(e_prdy));
        check_eq({tag, ".cmp"},    32'(cmp),  32'(e_cmp));
        check_eq({tag, ".vld"},    32'(vld),  32'(e_vld));
        check_eq({tag, ".len"},    32'(len),  32'(e_len));
        check_eq({tag, ".err"},    32'(err),  32'(e_err));
        check_eq({tag, ".badid"},  32'(bad),  32'(e_bad));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".bready"}, 32'(b_if.noc2mcif_axi_b_bready), 32'd0);
        check_eq({tag, ".prdy"},   32'(prdy), 32'd0);
        check_eq({tag, ".cmp"},    32'(cmp),  32'd0);
        check_eq({tag, ".vld"},    32'(vld),  32'd0);
        check_eq({tag, ".len"},    32'(len),  32'd0);
        check_eq({tag, ".err"},    32'(err),  32'd0);
        check_eq({tag, ".badid"},  32'(bad),  32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b0;
        b_if.noc2mcif_axi_b_bvalid = 1'b0;
        b_if.noc2mcif_axi_b_bid    = '0;
        b_if.noc2mcif_axi_b_bresp  = '0;
        pvld = '0;
        clr  = '0;
        // Every client: {len=2, ack=1} = 3'b101
        pd   = {5{3'b101}};
        #2;
        check_all_zero("reset");
        #10 rstn = 1'b1;

        // Back-to-back bids 0..4, all contexts present
        do_slot("b2b0", 1, 8'd0, 2'd0, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h00, 0);
        do_slot("b2b1", 1, 8'd1, 2'd0, 5'h1F, 5'h00, 1, 5'h01, 5'h00, 0, 2'd0, 5'h00, 0);
        do_slot("b2b2", 1, 8'd2, 2'd0, 5'h1F, 5'h00, 1, 5'h02, 5'h01, 1, 2'd2, 5'h00, 0);
        do_slot("b2b3", 1, 8'd3, 2'd0, 5'h1F, 5'h00, 1, 5'h04, 5'h02, 1, 2'd2, 5'h00, 0);
        do_slot("b2b4", 1, 8'd4, 2'd0, 5'h1F, 5'h00, 1, 5'h08, 5'h04, 1, 2'd2, 5'h00, 0);
        do_slot("b2b5", 0, 8'd0, 2'd0, 5'h1F, 5'h00, 1, 5'h10, 5'h08, 1, 2'd2, 5'h00, 0);
        do_slot("b2b6", 0, 8'd0, 2'd0, 5'h1F, 5'h00, 1, 5'h00, 5'h10, 1, 2'd2, 5'h00, 0);
        do_slot("b2b7", 0, 8'd0, 2'd0, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h00, 0);

        // Missing context for client 1 stalls the head; bid 0 and 2 queue behind it
        do_slot("stl0", 1, 8'd1, 2'd0, 5'h1D, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h00, 0);
        do_slot("stl1", 1, 8'd0, 2'd0, 5'h1D, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h00, 0);
        do_slot("stl2", 1, 8'd2, 2'd0, 5'h1D, 5'h00, 0, 5'h00, 5'h00, 0, 2'd0, 5'h00, 0);
        do_slot("stl3", 1, 8'd2, 2'd0, 5'h1D, 5'h00, 0, 5'h00, 5'h00, 0, 2'd0, 5'h00, 0);
        do_slot("stl4", 1, 8'd2, 2'd0, 5'h1F, 5'h00, 0, 5'h02, 5'h00, 0, 2'd0, 5'h00, 0);
        do_slot("stl5", 1, 8'd2, 2'd0, 5'h1F, 5'h00, 1, 5'h01, 5'h02, 1, 2'd2, 5'h00, 0);
        do_slot("stl6", 0, 8'd0, 2'd0, 5'h1F, 5'h00, 1, 5'h04, 5'h01, 1, 2'd2, 5'h00, 0);
        do_slot("stl7", 0, 8'd0, 2'd0, 5'h1F, 5'h00, 1, 5'h00, 5'h04, 1, 2'd2, 5'h00, 0);
        do_slot("stl8", 0, 8'd0, 2'd0, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h00, 0);

        // Out-of-range bid 6, then bid 0x08 (client 0, upper bits ignored)
        do_slot("bad0", 1, 8'd6,  2'd0, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h00, 0);
        do_slot("bad1", 1, 8'h08, 2'd0, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h00, 0);
        do_slot("bad2", 0, 8'd0,  2'd0, 5'h1F, 5'h00, 1, 5'h01, 5'h00, 0, 2'd0, 5'h00, 1);
        do_slot("bad3", 0, 8'd0,  2'd0, 5'h1F, 5'h00, 1, 5'h00, 5'h01, 1, 2'd2, 5'h00, 1);
        do_slot("bad4", 0, 8'd0,  2'd0, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h00, 1);

        // Client 3 error response, entry {len=1, ack=0}; clear, then set-vs-clear
        pd[3*3 +: 3] = 3'b010;
        do_slot("err0", 1, 8'd3, 2'b10, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h00, 1);
        do_slot("err1", 0, 8'd0, 2'b00, 5'h1F, 5'h00, 1, 5'h08, 5'h00, 0, 2'd0, 5'h00, 1);
        do_slot("err2", 0, 8'd0, 2'b00, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 1, 2'd1, 5'h08, 1);
        do_slot("err3", 0, 8'd0, 2'b00, 5'h1F, 5'h08, 1, 5'h00, 5'h00, 0, 2'd0, 5'h08, 1);
        do_slot("err4", 0, 8'd0, 2'b00, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h00, 1);
        do_slot("err5", 1, 8'd3, 2'b10, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h00, 1);
        do_slot("err6", 0, 8'd0, 2'b00, 5'h1F, 5'h08, 1, 5'h08, 5'h00, 0, 2'd0, 5'h00, 1);
        do_slot("err7", 0, 8'd0, 2'b00, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 1, 2'd1, 5'h08, 1);
        do_slot("err8", 0, 8'd0, 2'b00, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h08, 1);

        // Reset with two responses buffered behind missing contexts
        do_slot("rst0", 1, 8'd0, 2'd0, 5'h00, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h08, 1);
        do_slot("rst1", 1, 8'd1, 2'd0, 5'h00, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h08, 1);
        do_slot("rst2", 0, 8'd0, 2'd0, 5'h00, 5'h00, 0, 5'h00, 5'h00, 0, 2'd0, 5'h08, 1);
        #1 rstn = 1'b0;
        #1;
        check_all_zero("rst_mid");
        pvld = 5'h1F;
        #1;
        check_all_zero("rst_pvld");
        #3 rstn = 1'b1;
        do_slot("rst3", 0, 8'd0, 2'd0, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h00, 0);
        do_slot("rst4", 0, 8'd0, 2'd0, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h00, 0);
        do_slot("rst5", 0, 8'd0, 2'd0, 5'h1F, 5'h00, 1, 5'h00, 5'h00, 0, 2'd0, 5'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
